// File: rtl/inv_mix_column_iter.sv
// inv_mix_column_iter
// Iterative AES InvMixColumns: takes one 128-bit state via valid/ready,
// rewrites one 32-bit column per clock through a single shared GF(2^8)
// datapath, then presents the result via valid/ready.
//
// Optional build macro: INV_MIX_FWD_EN
//   Defined   - adds input `mode`, latched at accept; mode=1 selects the
//               forward MixColumns matrix, mode=0 the inverse one.
//   Undefined - inverse matrix only; no forward logic is present.
//
// state | meaning
// IDLE  | ready for a new block, in_ready=1
// PROC  | rewriting column r_col of the buffer each cycle
// DONE  | result held on mixed_state with out_valid=1 until out_ready
module inv_mix_column_iter #(
  parameter int BLOCK_LENGTH = 128,
  parameter int WORD_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] state,
`ifdef INV_MIX_FWD_EN
  input  logic                    mode,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] mixed_state,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t                    r_fsm;
  logic [1:0]              r_col;
  logic [BLOCK_LENGTH-1:0] r_buf;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
`ifdef INV_MIX_FWD_EN
  logic                    r_mode;
`endif

  logic [WORD_SIZE-1:0]    w_col;
  logic [WORD_SIZE-1:0]    w_mixed;
  logic [7:0]              w_a  [4];
  logic [7:0]              w_x2 [4];
  logic [7:0]              w_x4 [4];
  logic [7:0]              w_x8 [4];
  logic [7:0]              w_inv[4];
`ifdef INV_MIX_FWD_EN
  logic [7:0]              w_fwd[4];
`endif

  // Multiply by x in GF(2^8), reducing by 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign mixed_state = r_buf;

  // Select the column being processed; column 0 is the top word.
  always_comb begin
    w_col = r_buf[127:96];
    case (r_col)
      2'd0:    w_col = r_buf[127:96];
      2'd1:    w_col = r_buf[95:64];
      2'd2:    w_col = r_buf[63:32];
      default: w_col = r_buf[31:0];
    endcase
  end

  // Split into bytes (byte 0 is the MSB) and build the xtime chains once,
  // so every matrix coefficient is a XOR of shared partial products.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_a[i]  = w_col[31-8*i -: 8];
      w_x2[i] = xtime(w_a[i]);
      w_x4[i] = xtime(w_x2[i]);
      w_x8[i] = xtime(w_x4[i]);
    end
  end

  // Inverse circulant (0e 0b 0d 09):
  //   0e = x8^x4^x2, 0b = x8^x2^x, 0d = x8^x4^x, 09 = x8^x
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_inv[i] = (w_x8[i]         ^ w_x4[i]         ^ w_x2[i])
               ^ (w_x8[(i+1)%4]   ^ w_x2[(i+1)%4]   ^ w_a[(i+1)%4])
               ^ (w_x8[(i+2)%4]   ^ w_x4[(i+2)%4]   ^ w_a[(i+2)%4])
               ^ (w_x8[(i+3)%4]   ^ w_a[(i+3)%4]);
    end
  end

`ifdef INV_MIX_FWD_EN
  // Forward circulant (02 03 01 01), reusing the same x2 products.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_fwd[i] = w_x2[i]
               ^ (w_x2[(i+1)%4] ^ w_a[(i+1)%4])
               ^ w_a[(i+2)%4]
               ^ w_a[(i+3)%4];
    end
  end

  // Pick the matrix chosen when the block was accepted.
  always_comb begin
    w_mixed = {w_inv[0], w_inv[1], w_inv[2], w_inv[3]};
    if (r_mode)
      w_mixed = {w_fwd[0], w_fwd[1], w_fwd[2], w_fwd[3]};
  end
`else
  // Inverse-only build: result is the InvMix column.
  always_comb begin
    w_mixed = {w_inv[0], w_inv[1], w_inv[2], w_inv[3]};
  end
`endif

  // Control FSM with registered handshake outputs and the column buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_col       <= 2'd0;
      r_buf       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef INV_MIX_FWD_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_buf      <= state;
            r_col      <= 2'd0;
            r_fsm      <= S_PROC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef INV_MIX_FWD_EN
            r_mode     <= mode;
`endif
          end
        end
        S_PROC: begin
          case (r_col)
            2'd0:    r_buf[127:96] <= w_mixed;
            2'd1:    r_buf[95:64]  <= w_mixed;
            2'd2:    r_buf[63:32]  <= w_mixed;
            default: r_buf[31:0]   <= w_mixed;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Return to IDLE first; a new block is only taken on a later edge.
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= S_IDLE;
          r_col       <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column_iter.sv
// Directed testbench for inv_mix_column_iter.
module tb_inv_mix_column_iter;

  localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] KAT_MID = 128'hdb135345_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIX_IN  = 128'hc6c6c6c6_01010101_00000000_ffffffff;
  localparam logic [127:0] B_IN    = 128'h4d7ebdf8_4d7ebdf8_01010101_c6c6c6c6;
  localparam logic [127:0] B_OUT   = 128'h2d26314c_2d26314c_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mixed_state;
  logic         busy;
`ifdef INV_MIX_FWD_EN
  logic         mode;
`endif

  int total = 0;
  int bad   = 0;

  inv_mix_column_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state       (state),
`ifdef INV_MIX_FWD_EN
    .mode        (mode),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mixed_state (mixed_state),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Present one block for a single edge (DUT assumed idle), return 1ns after it.
  task automatic send(input logic [127:0] s);
    state    = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen, capped at 20.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; state = KAT_IN; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (mixed_state !== 128'h0) begin bad++; $display("FAIL reset_mixed got=%h exp=0", mixed_state); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_kat;
    int n;
    out_ready = 1'b1;
    send(KAT_IN);
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL kat_accept busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    @(posedge clk); #1;
    total++; if (mixed_state !== KAT_MID) begin bad++; $display("FAIL kat_col0 got=%h exp=%h", mixed_state, KAT_MID); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kat_early_valid got=%b exp=0", out_valid); end
    wait_out(n);
    total++; if (n + 1 !== 4) begin bad++; $display("FAIL kat_latency got=%0d exp=4", n + 1); end
    total++; if (mixed_state !== KAT_OUT) begin bad++; $display("FAIL kat_result got=%h exp=%h", mixed_state, KAT_OUT); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL kat_drain out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_fixed;
    int n;
    out_ready = 1'b1;
    send(FIX_IN);
    wait_out(n);
    total++; if (n !== 4) begin bad++; $display("FAIL fixed_latency got=%0d exp=4", n); end
    total++; if (mixed_state !== FIX_IN) begin bad++; $display("FAIL fixed_result got=%h exp=%h", mixed_state, FIX_IN); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    send(KAT_IN);
    wait_out(n);
    total++; if (n !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", n); end
    // A new block offered while DONE must not be taken.
    in_valid = 1'b1; state = FIX_IN;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ctl cyc=%0d out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready); end
      total++; if (mixed_state !== KAT_OUT) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, mixed_state, KAT_OUT); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept busy=%b exp=1", busy); end
    wait_out(n);
    total++; if (mixed_state !== FIX_IN) begin bad++; $display("FAIL bp_next_result got=%h exp=%h", mixed_state, FIX_IN); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_drop;
    int n;
    out_ready = 1'b1;
    send(KAT_IN);
    in_valid = 1'b1; state = B_IN;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drop_in_ready got=%b exp=0", in_ready); end
    wait_out(n);
    total++; if (mixed_state !== KAT_OUT) begin bad++; $display("FAIL drop_first_result got=%h exp=%h", mixed_state, KAT_OUT); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL drop_idle in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_pending_accept busy=%b exp=1", busy); end
    wait_out(n);
    total++; if (mixed_state[127:96] !== 32'h2d26314c) begin bad++; $display("FAIL drop_col0 got=%h exp=2d26314c", mixed_state[127:96]); end
    total++; if (mixed_state !== B_OUT) begin bad++; $display("FAIL drop_result got=%h exp=%h", mixed_state, B_OUT); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    out_ready = 1'b1;
    send(KAT_IN);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctl out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
    total++; if (mixed_state !== 128'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", mixed_state); end
    rst = 1'b0;
    send(KAT_IN);
    wait_out(n);
    total++; if (mixed_state !== KAT_OUT) begin bad++; $display("FAIL rstmid_rerun got=%h exp=%h", mixed_state, KAT_OUT); end
    @(posedge clk); #1;
  endtask

`ifdef INV_MIX_FWD_EN
  task automatic test_fwd;
    int n;
    out_ready = 1'b1;
    mode = 1'b1;
    send(KAT_OUT);
    mode = 1'b0;
    wait_out(n);
    total++; if (n !== 4) begin bad++; $display("FAIL fwd_latency got=%0d exp=4", n); end
    total++; if (mixed_state !== KAT_IN) begin bad++; $display("FAIL fwd_result got=%h exp=%h", mixed_state, KAT_IN); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; state = '0; out_ready = 1'b0;
`ifdef INV_MIX_FWD_EN
    mode = 1'b0;
`endif
    test_reset();
    test_kat();
    test_fixed();
    test_backpressure();
    test_busy_drop();
    test_reset_mid();
`ifdef INV_MIX_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
